// File: rtl/refill_pkg.sv
// Shared types and constants for the line refill engine: FSM encoding,
// line-size derivation and the byte-offset width of a word address.
package refill_pkg;

  localparam int BYTE_OFS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DELIVER,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int line_words(input int word_offset);
    return 1 << word_offset;
  endfunction

endpackage

// File: rtl/refill_word_ctr.sv
// Burst word sequencer: remembers the critical-word index and the number of
// words delivered, producing the wrapped line index and an all-done flag.
module refill_word_ctr
  import refill_pkg::*;
#(
  parameter int WORD_OFFSET = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WORD_OFFSET-1:0] start,
  input  logic                   inc,
  output logic [WORD_OFFSET-1:0] idx,
  output logic                   last
);

  localparam int LINE_WORDS = line_words(WORD_OFFSET);
  localparam logic [WORD_OFFSET:0] CNT_FULL = (WORD_OFFSET+1)'(LINE_WORDS);

  logic [WORD_OFFSET-1:0] start_q;
  logic [WORD_OFFSET:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      start_q <= start;
      cnt_q   <= '0;
    end else if (inc) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Index math is WORD_OFFSET bits wide so the burst wraps inside the line.
  assign idx  = start_q + cnt_q[WORD_OFFSET-1:0];
  assign last = (cnt_q == CNT_FULL);

endmodule

// File: rtl/line_refill_engine.sv
// Serves a cache line refill as critical-word-first single-word memory reads,
// handing each word back to the cache controller as a one-cycle pulse.
module line_refill_engine
  import refill_pkg::*;
#(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_OFFSET = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2cc,
  output logic                   req_rfe2mem,
  output logic [ADR_WIDTH-1:0]   adr_rfe2mem,
  input  logic                   ack_mem2rfe,
  input  logic [DATA_WIDTH-1:0]  dat_mem2rfe,
  output logic                   busy_rfe
);

  localparam int BASE_LO = WORD_OFFSET + BYTE_OFS;

  state_t state, next_state;

  logic [ADR_WIDTH-BASE_LO-1:0] base_q;
  logic                         abort_q;
  logic                         ctr_load, ctr_inc, capture;
  logic [WORD_OFFSET-1:0]       idx;
  logic                         last;
  logic                         unused_byte_bits;

  assign unused_byte_bits = ^adr_cc2mem[BYTE_OFS-1:0];

  refill_word_ctr #(.WORD_OFFSET(WORD_OFFSET)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .start (adr_cc2mem[BASE_LO-1:BYTE_OFS]),
    .inc   (ctr_inc),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_cc2mem) begin
          ctr_load   = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An abandoned read must still complete on the bus before leaving.
        if (ack_mem2rfe) begin
          if (abort_q || !req_cc2mem) begin
            next_state = ST_IDLE;
          end else begin
            capture    = 1'b1;
            next_state = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        ctr_inc    = 1'b1;
        next_state = req_cc2mem ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (!req_cc2mem) next_state = ST_IDLE;
        else if (last)   next_state = ST_DONE;
        else             next_state = ST_ISSUE;
      end
      ST_DONE: begin
        if (!req_cc2mem) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      abort_q     <= 1'b0;
      req_rfe2mem <= 1'b0;
      ack_mem2cc  <= 1'b0;
      dat_mem2cc  <= '0;
      word_mem2cc <= '0;
    end else begin
      if (ctr_load) base_q <= adr_cc2mem[ADR_WIDTH-1:BASE_LO];
      abort_q     <= (next_state == ST_ISSUE) &&
                     (abort_q || (state == ST_ISSUE && !req_cc2mem));
      req_rfe2mem <= (next_state == ST_ISSUE);
      ack_mem2cc  <= (next_state == ST_DELIVER);
      if (capture) begin
        dat_mem2cc  <= dat_mem2rfe;
        word_mem2cc <= idx;
      end
    end
  end

  assign adr_rfe2mem = {base_q, idx, {BYTE_OFS{1'b0}}};
  assign busy_rfe    = (state != ST_IDLE);

endmodule
